// File: rtl/uart_pkg.sv
// Shared UART encodings and FSM states, used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_ODD      = 2'd1;
  localparam logic [1:0] PAR_EVEN     = 2'd2;
  localparam logic [1:0] PAR_NONE_ALT = 2'd3;

  localparam logic [1:0] STOP_ONE     = 2'd0;
  localparam logic [1:0] STOP_ONE_ALT = 2'd1;
  localparam logic [1:0] STOP_TWO     = 2'd2;
  localparam logic [1:0] STOP_TWO_ALT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic logic parity_enabled(input logic [1:0] par);
    case (par)
      PAR_ODD, PAR_EVEN:      return 1'b1;
      PAR_NONE, PAR_NONE_ALT: return 1'b0;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_two_stop(input logic [1:0] stop);
    case (stop)
      STOP_TWO, STOP_TWO_ALT: return 1'b1;
      STOP_ONE, STOP_ONE_ALT: return 1'b0;
      default:                return 1'b0;
    endcase
  endfunction

  // Out-of-range data-bit settings saturate into 5..max_bits.
  function automatic logic [3:0] clamp_bits(input logic [3:0] cfg, input logic [3:0] max_bits);
    if (cfg < 4'd5) return 4'd5;
    if (cfg > max_bits) return max_bits;
    return cfg;
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Valid/ready output channel of the UART receiver.
interface uart_rx_core_if #(
  parameter int unsigned MAX_DATA_BITS = 9
);
  logic                     m_valid;
  logic                     m_ready;
  logic [MAX_DATA_BITS-1:0] m_data;
  logic                     m_parity_err;
  logic                     m_frame_err;
  logic                     m_break;

  modport master (
    output m_valid,
    output m_data,
    output m_parity_err,
    output m_frame_err,
    output m_break,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_parity_err,
    input  m_frame_err,
    input  m_break,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= {2{ResetValue}};
    end else begin
      ff_q <= {ff_q[0], d};
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: majority-voted bit recovery, 5-9 data bits, optional parity,
// 1 or 2 stop bits, and a valid/ready output register with overrun detection.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned MAX_DATA_BITS = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic               sample_tick,
  input  logic [3:0]         cfg_data_bits,
  input  logic [1:0]         cfg_parity,
  input  logic [1:0]         cfg_stop_bits,
  uart_rx_core_if.master     m,
  output logic               overrun
);

  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam int unsigned TW = $clog2(OVERSAMPLE);

  typedef logic [TW-1:0] tcnt_t;

  localparam tcnt_t      TickPre  = tcnt_t'(M - 1);
  localparam tcnt_t      TickMid  = tcnt_t'(M);
  localparam tcnt_t      TickDec  = tcnt_t'(M + 1);
  localparam tcnt_t      TickLast = tcnt_t'(OVERSAMPLE - 1);
  localparam logic [3:0] MaxBits  = 4'(MAX_DATA_BITS);

  logic rxs;

  uart_rx_sync #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rxs)
  );

  uart_state_e              state_q, state_d;
  tcnt_t                    tcnt_q, tcnt_d;
  logic [3:0]               bitcnt_q, bitcnt_d;
  logic                     stopcnt_q, stopcnt_d;
  logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                     s0_q, s0_d, s1_q, s1_d;
  logic [3:0]               nbits_q, nbits_d;
  logic [1:0]               par_q, par_d;
  logic                     two_stop_q, two_stop_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     all_low_q, all_low_d;
  logic                     arm_q, arm_d;

  logic                     maj;
  logic                     comp;
  logic [MAX_DATA_BITS-1:0] comp_data;
  logic                     comp_perr, comp_ferr, comp_brk;

  logic                     valid_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic                     perr_out_q, ferr_out_q, brk_out_q;
  logic                     overrun_q;

  assign maj = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bitcnt_d   = bitcnt_q;
    stopcnt_d  = stopcnt_q;
    shreg_d    = shreg_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    all_low_d  = all_low_q;
    arm_d      = arm_q;
    comp       = 1'b0;
    comp_data  = '0;
    comp_perr  = 1'b0;
    comp_ferr  = 1'b0;
    comp_brk   = 1'b0;

    if (sample_tick) begin
      if (rxs) arm_d = 1'b1;

      if (state_q != IDLE) begin
        tcnt_d = (tcnt_q == TickLast) ? '0 : tcnt_q + tcnt_t'(1);
        if (tcnt_q == TickPre) s0_d = rxs;
        if (tcnt_q == TickMid) s1_d = rxs;
      end

      unique case (state_q)
        IDLE: begin
          if (!rxs && arm_q) begin
            state_d    = START;
            tcnt_d     = tcnt_t'(1);
            nbits_d    = clamp_bits(cfg_data_bits, MaxBits);
            par_d      = cfg_parity;
            two_stop_d = is_two_stop(cfg_stop_bits);
            bitcnt_d   = '0;
            stopcnt_d  = 1'b0;
            shreg_d    = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            all_low_d  = 1'b1;
          end
        end
        START: begin
          if (tcnt_q == TickDec && maj) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (tcnt_q == TickLast) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (tcnt_q == TickDec) begin
            shreg_d   = {maj, shreg_q[MAX_DATA_BITS-1:1]};
            all_low_d = all_low_q & ~maj;
          end
          if (tcnt_q == TickLast) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q + 4'd1 == nbits_q) begin
              state_d = parity_enabled(par_q) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          // Unfilled shift-register bits are zero, so reducing the whole register is safe.
          if (tcnt_q == TickDec) begin
            perr_d    = (par_q == PAR_ODD) ? (maj != ~^shreg_q) : (maj != ^shreg_q);
            all_low_d = all_low_q & ~maj;
          end
          if (tcnt_q == TickLast) state_d = STOP;
        end
        STOP: begin
          if (tcnt_q == TickDec) begin
            if (!maj) ferr_d = 1'b1;
            all_low_d = all_low_q & ~maj;
            if (stopcnt_q == two_stop_q) begin
              // Final stop completes mid-bit to leave resynchronisation margin.
              comp      = 1'b1;
              comp_data = shreg_q >> (MAX_DATA_BITS - 32'(nbits_q));
              comp_perr = perr_q;
              comp_ferr = ferr_q | ~maj;
              comp_brk  = all_low_q & ~maj;
              state_d   = IDLE;
              tcnt_d    = '0;
              if (comp_ferr) arm_d = 1'b0;
            end
          end
          if (tcnt_q == TickLast) stopcnt_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      bitcnt_q   <= '0;
      stopcnt_q  <= 1'b0;
      shreg_q    <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      nbits_q    <= 4'd5;
      par_q      <= PAR_NONE;
      two_stop_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      all_low_q  <= 1'b0;
      arm_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bitcnt_q   <= bitcnt_d;
      stopcnt_q  <= stopcnt_d;
      shreg_q    <= shreg_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      all_low_q  <= all_low_d;
      arm_q      <= arm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_out_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (comp) begin
        if (valid_q && !m.m_ready) begin
          overrun_q <= 1'b1;
        end else begin
          valid_q    <= 1'b1;
          data_q     <= comp_data;
          perr_out_q <= comp_perr;
          ferr_out_q <= comp_ferr;
          brk_out_q  <= comp_brk;
        end
      end else if (valid_q && m.m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m.m_valid      = valid_q;
  assign m.m_data       = data_q;
  assign m.m_parity_err = perr_out_q;
  assign m.m_frame_err  = ferr_out_q;
  assign m.m_break      = brk_out_q;
  assign overrun        = overrun_q;

endmodule
